// File: rtl/diamond_collector_if.sv
// Player position / frame strobe in, collection status out for diamond_collector.
interface diamond_collector_if;
  logic       frame_clk;
  logic       level_restart;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [3:0] is_diamond_eat;
  logic [2:0] diamond_count;
  logic       eat_pulse;
  logic       diamond_flash;
  logic       all_collected;

  modport master (
    output frame_clk, level_restart, player_x, player_y,
    input  is_diamond_eat, diamond_count, eat_pulse, diamond_flash, all_collected
  );

  modport slave (
    input  frame_clk, level_restart, player_x, player_y,
    output is_diamond_eat, diamond_count, eat_pulse, diamond_flash, all_collected
  );
endinterface

// File: rtl/diamond_collector.sv
// Per-frame diamond pickup: snapshots the player on each frame tick, then tests
// one diamond per cycle for box overlap and records new collections.
module diamond_collector #(
  parameter int PLAYER_W     = 20,
  parameter int PLAYER_H     = 28,
  parameter int D_SIZE       = 20,
  parameter int D0_X         = 458,
  parameter int D0_Y         = 408,
  parameter int D1_X         = 120,
  parameter int D1_Y         = 300,
  parameter int D2_X         = 300,
  parameter int D2_Y         = 200,
  parameter int D3_X         = 540,
  parameter int D3_Y         = 100,
  parameter int FLASH_FRAMES = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  diamond_collector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e      state_q;
  logic        frame_clk_q;
  logic [1:0]  idx_q;
  logic [9:0]  sx_q, sy_q;
  logic [3:0]  eat_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        pulse_q;
  logic [3:0]  flash_q, flash_d;

  logic        frame_tick;
  logic [10:0] dx, dy, sx, sy;
  logic        overlap, new_eat;

  assign frame_tick = bus.frame_clk & ~frame_clk_q;

  always_comb begin
    dx = '0;
    dy = '0;
    case (idx_q)
      2'd0: begin dx = 11'(D0_X); dy = 11'(D0_Y); end
      2'd1: begin dx = 11'(D1_X); dy = 11'(D1_Y); end
      2'd2: begin dx = 11'(D2_X); dy = 11'(D2_Y); end
      default: begin dx = 11'(D3_X); dy = 11'(D3_Y); end
    endcase
  end

  // 11-bit compares keep sx+W and Dx+SIZE from wrapping; edges are half-open.
  assign sx      = {1'b0, sx_q};
  assign sy      = {1'b0, sy_q};
  assign overlap = (sx < dx + 11'(D_SIZE)) && (sx + 11'(PLAYER_W) > dx) &&
                   (sy < dy + 11'(D_SIZE)) && (sy + 11'(PLAYER_H) > dy);
  assign new_eat = (state_q == SCAN) && overlap && !eat_q[idx_q];

  assign cnt_d   = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
  assign flash_d = (frame_tick && flash_q != 4'd0) ? flash_q - 4'd1 : flash_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_clk_q <= 1'b0;
      idx_q       <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      eat_q       <= '0;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      flash_q     <= '0;
    end else begin
      frame_clk_q <= bus.frame_clk;
      if (bus.level_restart) begin
        state_q <= IDLE;
        idx_q   <= '0;
        eat_q   <= '0;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        flash_q <= '0;
      end else begin
        pulse_q <= 1'b0;
        flash_q <= flash_d;
        case (state_q)
          IDLE: if (frame_tick) begin
            sx_q    <= bus.player_x;
            sy_q    <= bus.player_y;
            idx_q   <= '0;
            state_q <= SCAN;
          end
          SCAN: begin
            // A fresh collection reloads the flash, overriding this cycle's decrement.
            if (new_eat) begin
              eat_q[idx_q] <= 1'b1;
              cnt_q        <= cnt_d;
              pulse_q      <= 1'b1;
              flash_q      <= 4'(FLASH_FRAMES);
            end
            if (idx_q == 2'd3) state_q <= DONE;
            else               idx_q   <= idx_q + 2'd1;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.is_diamond_eat = eat_q;
  assign bus.diamond_count  = cnt_q;
  assign bus.eat_pulse      = pulse_q;
  assign bus.diamond_flash  = (flash_q != 4'd0);
  assign bus.all_collected  = (cnt_q == 3'd4);

endmodule

// File: tb/tb_diamond_collector.sv
// Directed frame table, restart/reset corner sequences and random frames
// checked against a frame-level collection model.
module tb_diamond_collector;
  localparam int PW = 20;
  localparam int PH = 28;
  localparam int DS = 20;
  localparam int DXS [4] = '{458, 120, 300, 540};
  localparam int DYS [4] = '{408, 300, 200, 100};

  typedef struct {
    bit         restart;
    int         x, y;
    logic [7:0] pat;
    logic [3:0] eat;
    int         cnt;
    bit         flash;
    bit         all;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  diamond_collector_if bus();

  diamond_collector dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] m_eat;
  int m_flash;
  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit r, input int x, input int y, input logic [7:0] p,
                     input logic [3:0] e, input int c, input bit f, input bit a);
    vec_t v;
    v.restart = r; v.x = x; v.y = y; v.pat = p; v.eat = e; v.cnt = c; v.flash = f; v.all = a;
    vecs.push_back(v);
  endtask

  function automatic bit ov(input int x, input int y, input int i);
    return (x < DXS[i] + DS) && (x + PW > DXS[i]) && (y < DYS[i] + DS) && (y + PH > DYS[i]);
  endfunction

  // Model: each frame decrements the flash, then any newly overlapped
  // diamond is collected (pulse at sample 1+i) and reloads the flash to 8.
  task automatic model_frame(input int x, input int y, output logic [7:0] pat);
    pat = '0;
    m_flash = (m_flash > 0) ? m_flash - 1 : 0;
    for (int i = 0; i < 4; i++)
      if (ov(x, y, i) && !m_eat[i]) begin
        m_eat[i]   = 1'b1;
        pat[1 + i] = 1'b1;
        m_flash    = 8;
      end
  endtask

  task automatic do_restart();
    @(negedge Clk) bus.level_restart = 1'b1;
    @(negedge Clk) bus.level_restart = 1'b0;
  endtask

  // One frame: rising frame_clk with the player at (x,y); live inputs are
  // scrambled after the tick so only the snapshot can produce a hit.
  task automatic do_frame(input int x, input int y, output logic [7:0] pat);
    @(negedge Clk);
    bus.player_x  = 10'(x);
    bus.player_y  = 10'(y);
    bus.frame_clk = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge Clk);
      pat[j] = bus.eat_pulse;
      if (j == 0) begin
        bus.player_x = 10'($urandom);
        bus.player_y = 10'($urandom);
      end
      if (j == 2) bus.frame_clk = 1'b0;
    end
  endtask

  task automatic check_model(input string tag, input logic [7:0] exp_pat, input logic [7:0] pat);
    chk({tag, " pulses"}, 32'(pat), 32'(exp_pat));
    chk({tag, " eat"},    32'(bus.is_diamond_eat), 32'(m_eat));
    chk({tag, " count"},  32'(bus.diamond_count), 32'($countones(m_eat)));
    chk({tag, " flash"},  32'(bus.diamond_flash), 32'(m_flash != 0));
    chk({tag, " all"},    32'(bus.all_collected), 32'($countones(m_eat) == 4));
  endtask

  initial begin
    logic [7:0] pat, exp_pat;
    int npulse, x, y, d;

    Reset = 1'b1;
    bus.frame_clk = 1'b0; bus.level_restart = 1'b0;
    bus.player_x = '0; bus.player_y = '0;
    repeat (3) @(negedge Clk);
    chk("reset eat",   32'(bus.is_diamond_eat), 0);
    chk("reset count", 32'(bus.diamond_count), 0);
    chk("reset pulse", 32'(bus.eat_pulse), 0);
    chk("reset flash", 32'(bus.diamond_flash), 0);
    chk("reset all",   32'(bus.all_collected), 0);
    Reset = 1'b0;

    // restart, x, y, pulse samples, eat, count, flash, all
    add(0, 450, 400, 8'h02, 4'h1, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 450, 400, 8'h00, 4'h1, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 8'h00, 4'h1, 1, 1, 0);
    add(0, 0, 0, 8'h00, 4'h1, 1, 0, 0);
    add(1, 438, 408, 8'h00, 4'h0, 0, 0, 0);
    add(0, 439, 408, 8'h02, 4'h1, 1, 1, 0);
    add(0, 120, 300, 8'h04, 4'h3, 2, 1, 0);
    add(0, 300, 200, 8'h08, 4'h7, 3, 1, 0);
    add(0, 540, 100, 8'h10, 4'hF, 4, 1, 1);
    add(0, 540, 100, 8'h00, 4'hF, 4, 1, 1);
    add(0, 450, 400, 8'h00, 4'hF, 4, 1, 1);

    foreach (vecs[k]) begin
      if (vecs[k].restart) do_restart();
      do_frame(vecs[k].x, vecs[k].y, pat);
      chk($sformatf("vec%0d pulses", k), 32'(pat), 32'(vecs[k].pat));
      chk($sformatf("vec%0d eat", k),    32'(bus.is_diamond_eat), 32'(vecs[k].eat));
      chk($sformatf("vec%0d count", k),  32'(bus.diamond_count), 32'(vecs[k].cnt));
      chk($sformatf("vec%0d flash", k),  32'(bus.diamond_flash), 32'(vecs[k].flash));
      chk($sformatf("vec%0d all", k),    32'(bus.all_collected), 32'(vecs[k].all));
    end

    // level_restart coincident with a frame tick over D1: clears, tick dropped.
    @(negedge Clk);
    bus.player_x = 10'd120; bus.player_y = 10'd300;
    bus.frame_clk = 1'b1; bus.level_restart = 1'b1;
    @(negedge Clk);
    bus.level_restart = 1'b0;
    chk("restart eat",   32'(bus.is_diamond_eat), 0);
    chk("restart count", 32'(bus.diamond_count), 0);
    chk("restart pulse", 32'(bus.eat_pulse), 0);
    chk("restart flash", 32'(bus.diamond_flash), 0);
    npulse = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge Clk);
      npulse += int'(bus.eat_pulse);
      if (j == 2) bus.frame_clk = 1'b0;
    end
    chk("restart dropped tick pulses", 32'(npulse), 0);

    // Reset one cycle into a scan that would collect D1.
    @(negedge Clk);
    bus.player_x = 10'd120; bus.player_y = 10'd300; bus.frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1; bus.frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midscan reset eat",   32'(bus.is_diamond_eat), 0);
    chk("midscan reset count", 32'(bus.diamond_count), 0);
    chk("midscan reset pulse", 32'(bus.eat_pulse), 0);
    chk("midscan reset flash", 32'(bus.diamond_flash), 0);
    chk("midscan reset all",   32'(bus.all_collected), 0);
    npulse = 0;
    repeat (6) begin
      @(negedge Clk);
      npulse += int'(bus.eat_pulse);
    end
    chk("midscan reset no late pulse", 32'(npulse), 0);
    m_eat = '0; m_flash = 0;
    model_frame(120, 300, exp_pat);
    do_frame(120, 300, pat);
    check_model("post reset", exp_pat, pat);

    // A second frame tick during SCAN is ignored (no snapshot of D2).
    @(negedge Clk);
    bus.player_x = 10'd0; bus.player_y = 10'd0; bus.frame_clk = 1'b1;
    @(negedge Clk);
    bus.frame_clk = 1'b0; bus.player_x = 10'd300; bus.player_y = 10'd200;
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    npulse = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge Clk);
      npulse += int'(bus.eat_pulse);
      if (j == 1) bus.frame_clk = 1'b0;
    end
    m_flash = (m_flash > 2) ? m_flash - 2 : 0;
    chk("scan tick ignored pulses", 32'(npulse), 0);
    chk("scan tick ignored count", 32'(bus.diamond_count), 32'($countones(m_eat)));
    chk("scan tick flash", 32'(bus.diamond_flash), 32'(m_flash != 0));

    // Random frames near the diamonds against the model.
    do_restart();
    m_eat = '0; m_flash = 0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        do_restart();
        m_eat = '0; m_flash = 0;
      end
      d = int'($urandom_range(0, 3));
      x = DXS[d] + int'($urandom_range(0, 50)) - 25;
      y = DYS[d] + int'($urandom_range(0, 60)) - 35;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      model_frame(x, y, exp_pat);
      do_frame(x, y, pat);
      check_model($sformatf("rand%0d", n), exp_pat, pat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
